// File: rtl/shift_ser_ctrl.sv
// Frame controller for an external serial shift register: clears it, clocks WIDTH bits in, then
// holds the frame until the consumer takes it. Define SHIFT_SER_PARITY_EN for a leading parity bit.
module shift_ser_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_ready,
  input  logic                           i_q,
  output logic                           o_serclk,
  output logic                           o_shreset,
  output logic                           o_busy,
  output logic                           o_valid,
  output logic [$clog2(WIDTH+2)-1:0]     o_bitcnt
`ifdef SHIFT_SER_PARITY_EN
  ,
  output logic                           o_perr
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);
`ifdef SHIFT_SER_PARITY_EN
  localparam int unsigned NumEdges = WIDTH + 1;
`else
  localparam int unsigned NumEdges = WIDTH;
`endif
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [CntW-1:0] EdgeFinal = CntW'(NumEdges - 1);

  typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            serclk_q, serclk_d;
  logic [CntW-1:0] bitcnt_q, bitcnt_d;
  logic            valid_q, valid_d;
  logic            fall_edge;

  // Serial clock is high and its half-period expires: this cycle issues a falling edge.
  assign fall_edge = (state_q == StShift) && serclk_q && (div_q == DivLast);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    serclk_d = 1'b0;
    bitcnt_d = bitcnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StClear;
      end
      StClear: begin
        state_d = StShift;
      end
      StShift: begin
        serclk_d = serclk_q;
        if (div_q == DivLast) begin
          div_d    = '0;
          serclk_d = ~serclk_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (fall_edge) begin
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == EdgeFinal) state_d = StDone;
        end
      end
      StDone: begin
        if (i_ready) state_d = i_start ? StClear : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Entering CLEAR (from IDLE or back-to-back from DONE) starts a fresh frame.
    if (state_d == StClear) begin
      bitcnt_d = '0;
      div_d    = '0;
    end
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      serclk_q <= 1'b0;
      bitcnt_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      serclk_q <= serclk_d;
      bitcnt_q <= bitcnt_d;
      valid_q  <= valid_d;
    end
  end

`ifdef SHIFT_SER_PARITY_EN
  logic perr_q, perr_d;

  // i_q is sampled on the same edge the shifter consumes it.
  always_comb begin
    perr_d = perr_q;
    if (fall_edge) perr_d = perr_q ^ i_q;
    if (state_d == StClear) perr_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign o_perr = perr_q;
`else
  logic unused_q;
  assign unused_q = i_q;
`endif

  assign o_serclk  = serclk_q;
  // Combinational so the shifter clears together with the controller under reset.
  assign o_shreset = i_reset & (state_q != StClear);
  assign o_busy    = (state_q == StClear) || (state_q == StShift);
  assign o_valid   = valid_q;
  assign o_bitcnt  = bitcnt_q;

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Bench for shift_ser_ctrl: two instances (DIV=4 and DIV=1) share stimulus and are checked every
// cycle against a frame-timeline model, plus directed scenarios with hand-computed expectations.
module tb_shift_ser_ctrl;

  localparam int W    = 8;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;
`ifdef SHIFT_SER_PARITY_EN
  localparam int N      = W + 1;
  localparam int EXP_S0 = 72;
  localparam int EXP_S1 = 18;
`else
  localparam int N      = W;
  localparam int EXP_S0 = 64;
  localparam int EXP_S1 = 16;
`endif
  localparam int BW = $clog2(W + 2);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0, q = 1'b0;
  logic [1:0] serclk, shreset, busy, valid;
  logic [BW-1:0] bitcnt0, bitcnt1;
`ifdef SHIFT_SER_PARITY_EN
  logic [1:0] perr;
`endif

  int total = 0;
  int bad = 0;

  shift_ser_ctrl #(.WIDTH(W), .DIV(DIV0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_ready(ready), .i_q(q),
    .o_serclk(serclk[0]), .o_shreset(shreset[0]), .o_busy(busy[0]), .o_valid(valid[0]),
    .o_bitcnt(bitcnt0)
`ifdef SHIFT_SER_PARITY_EN
    , .o_perr(perr[0])
`endif
  );

  shift_ser_ctrl #(.WIDTH(W), .DIV(DIV1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_ready(ready), .i_q(q),
    .o_serclk(serclk[1]), .o_shreset(shreset[1]), .o_busy(busy[1]), .o_valid(valid[1]),
    .o_bitcnt(bitcnt1)
`ifdef SHIFT_SER_PARITY_EN
    , .o_perr(perr[1])
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: phase 0 idle, 1 clear, 2 shift, 3 done; t = cycles since SHIFT entry.
  int m_ph[2];
  int m_t[2];
  int m_bc[2];
  bit m_par[2];

  function automatic int div_of(int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  function automatic void model_reset(int k);
    m_ph[k] = 0; m_t[k] = 0; m_bc[k] = 0; m_par[k] = 1'b0;
  endfunction

  function automatic void model_step(int k);
    case (m_ph[k])
      0: if (start) begin m_ph[k] = 1; m_bc[k] = 0; m_par[k] = 1'b0; end
      1: begin m_ph[k] = 2; m_t[k] = 0; end
      2: begin
        m_t[k]++;
        if (m_t[k] % (2 * div_of(k)) == 0) begin
          m_bc[k]++;
          m_par[k] ^= q;
          if (m_bc[k] == N) m_ph[k] = 3;
        end
      end
      default: if (ready) begin
        if (start) begin m_ph[k] = 1; m_bc[k] = 0; m_par[k] = 1'b0; end
        else m_ph[k] = 0;
      end
    endcase
  endfunction

  // Compare on the falling clock edge, then advance with the inputs the next rising edge sees.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (!rst) model_reset(k);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("serclk[%0d]", k), serclk[k],
            (m_ph[k] == 2) ? ((m_t[k] / div_of(k)) % 2) : 0);
        chk($sformatf("shreset[%0d]", k), shreset[k], (rst && m_ph[k] != 1) ? 1 : 0);
        chk($sformatf("busy[%0d]", k), busy[k], (m_ph[k] == 1 || m_ph[k] == 2) ? 1 : 0);
        chk($sformatf("valid[%0d]", k), valid[k], (m_ph[k] == 3) ? 1 : 0);
        chk($sformatf("bitcnt[%0d]", k), (k == 0) ? int'(bitcnt0) : int'(bitcnt1), m_bc[k]);
`ifdef SHIFT_SER_PARITY_EN
        chk($sformatf("perr[%0d]", k), perr[k], int'(m_par[k]));
`endif
      end
      for (int k = 0; k < 2; k++) begin
        if (!rst) model_reset(k);
        else model_step(k);
      end
    end
  end

  // Reference shift register on the DIV=4 instance, shifting MSB-first on serclk falling edges.
  logic [7:0] shreg = 8'h00;
  always @(negedge serclk[0] or negedge shreset[0]) begin
    if (!shreset[0]) shreg <= 8'h00;
    else shreg <= {shreg[6:0], q};
  end

  bit         par_mode = 1'b0;
  logic [8:0] stream = 9'h000;
  int fr_clr, fr_sh0, fr_sh1, fr_fe, fr_febad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_q();
    int idx;
    idx = 8 - int'(bitcnt0);
    if (par_mode) q = (idx >= 0) ? stream[idx] : 1'b0;
    else q = 1'($urandom % 2);
  endtask

  task automatic run_frame(input bit noise);
    int  last_fe;
    bit  prev;
    last_fe = -1; prev = 1'b0;
    fr_clr = 0; fr_sh0 = 0; fr_sh1 = 0; fr_fe = 0; fr_febad = 0;
    ready = 1'b0;
    start = 1'b1;
    drive_q();
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!shreset[0]) fr_clr++;
      if (busy[0] && shreset[0]) fr_sh0++;
      if (busy[1] && shreset[1]) fr_sh1++;
      if (prev && !serclk[0]) begin
        fr_fe++;
        if (last_fe >= 0 && c - last_fe != 2 * DIV0) fr_febad++;
        last_fe = c;
      end
      prev = serclk[0];
      if (valid[0]) break;
      start = noise ? 1'($urandom % 2) : 1'b0;
      drive_q();
    end
    start = 1'b0;
    chk("frame_done", valid[0], 1);
  endtask

  task automatic wait_valid0(input int lim);
    for (int c = 0; c < lim && !valid[0]; c++) tick();
    chk("wait_valid0", valid[0], 1);
  endtask

  task automatic release_frame();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    int cnt;
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("reset_shreset", shreset[0], 0);
    chk("reset_valid", valid[0], 0);
    chk("reset_busy", busy[0], 0);
    chk("reset_serclk", serclk[0], 0);
    chk("reset_bitcnt", bitcnt0, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Basic frame with i_start noise during the frame.
    run_frame(1'b1);
    chk("clear_cycles", fr_clr, 1);
    chk("shift_cycles_div4", fr_sh0, EXP_S0);
    chk("shift_cycles_div1", fr_sh1, EXP_S1);
    chk("fall_edges", fr_fe, N);
    chk("fall_spacing_bad", fr_febad, 0);
    chk("bitcnt_done", bitcnt0, N);

    // Consumer stalls for 20 cycles.
    cnt = 0;
    repeat (20) begin
      tick();
      if (!valid[0] || serclk[0]) cnt++;
    end
    chk("hold_bad_cycles", cnt, 0);
    release_frame();
    chk("release_valid", valid[0], 0);
    chk("release_busy", busy[0], 0);

    // Back-to-back frames.
    run_frame(1'b0);
    start = 1'b1;
    ready = 1'b1;
    tick();
    chk("b2b_shreset", shreset[0], 0);
    chk("b2b_busy", busy[0], 1);
    start = 1'b0;
    ready = 1'b0;
    wait_valid0(200);
    release_frame();

    // Reset abort after the third falling edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && bitcnt0 != 3; c++) tick();
    chk("abort_reach3", bitcnt0, 3);
    rst = 1'b0;
    #1;
    chk("abort_serclk", serclk[0], 0);
    chk("abort_shreset", shreset[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_valid", valid[0], 0);
    chk("abort_bitcnt", bitcnt0, 0);
    repeat (2) tick();
    rst = 1'b1;
    cnt = 0;
    repeat (2 * DIV0 * N + 20) begin
      tick();
      if (valid[0] || busy[0]) cnt++;
    end
    chk("abort_stay_idle", cnt, 0);
    run_frame(1'b0);
    chk("after_abort_bitcnt", bitcnt0, N);
    chk("after_abort_shift", fr_sh0, EXP_S0);
    release_frame();

    // Known stream: optional parity bit then 8'hA5 MSB-first.
    par_mode = 1'b1;
    for (int p = 1; p >= 0; p--) begin
`ifdef SHIFT_SER_PARITY_EN
      stream = {1'(p), 8'hA5};
`else
      stream = {8'hA5, 1'b0};
`endif
      run_frame(1'b0);
      chk("stream_edges", fr_fe, N);
      chk("stream_shreg", shreg, 8'hA5);
`ifdef SHIFT_SER_PARITY_EN
      chk("stream_perr", perr[0], p);
`endif
      release_frame();
    end
    par_mode = 1'b0;

    // Random traffic, including occasional resets.
    repeat (4000) begin
      start = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 2) == 0);
      q     = 1'($urandom % 2);
      rst   = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_ser_ctrl.md
SHIFT_SER_CTRL -- requirements
Module: shift_ser_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame data bits; must match the attached shift register width.
REQ-002 SHALL have parameter DIV, default 4, o_serclk half-period in i_clk cycles; legal range is DIV >= 1.
REQ-003 SHALL have i_clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have i_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have i_start, input, 1, request capture of one frame.
REQ-006 SHALL have i_ready, input, 1, consumer accepts the completed frame.
REQ-007 SHALL have i_q, input, 1, serial data line, same net as the shifter's i_q.
REQ-008 SHALL have o_serclk, output, 1, serial clock to the shifter; the shifter shifts on its falling edge.
REQ-009 SHALL have o_shreset, output, 1, active-low clear to the shifter.
REQ-010 SHALL have o_busy, output, 1, high in CLEAR and SHIFT.
REQ-011 SHALL have o_valid, output, 1, frame complete; the shifter output is stable.
REQ-012 SHALL have o_bitcnt, output, clog2(WIDTH+2), falling edges issued in the current frame.

Function
REQ-013 SHALL implement four states with these transitions:
  - IDLE -> CLEAR on i_start.
  - CLEAR -> SHIFT after exactly 1 cycle.
  - SHIFT -> DONE when the last edge is issued.
  - DONE -> IDLE on i_ready.
REQ-014 SHALL drive o_shreset low for exactly the one CLEAR cycle and high in all other states.
REQ-015 SHALL hold o_serclk low in IDLE, CLEAR and DONE.
REQ-016 SHALL run o_serclk in SHIFT as follows:
  - Starts low.
  - Toggles every DIV cycles via a divider counter, giving a period of 2*DIV cycles.
  - The first rising edge occurs DIV cycles after SHIFT entry.
REQ-017 SHALL increment o_bitcnt on each 1->0 transition of o_serclk; o_bitcnt is cleared in CLEAR.
REQ-018 SHALL enter DONE on the cycle the final falling edge is issued (edge WIDTH, or WIDTH+1 when parity is enabled).
  - Total SHIFT duration is 2*DIV*N cycles, where N is that edge count.
REQ-019 SHALL assert o_valid in DONE only and hold it until i_ready is sampled high; o_valid is registered.
REQ-020 SHALL take DONE directly to CLEAR when i_ready and i_start are high in the same DONE cycle (back-to-back frames).
REQ-021 SHALL ignore i_start in CLEAR and SHIFT; no queuing.
REQ-022 SHALL ignore i_ready outside DONE.
REQ-023 SHALL make o_serclk glitch-free, driven directly from a flop.

Reset
REQ-024 SHALL, while i_reset is low:
  - Force state to IDLE and clear the divider and o_bitcnt.
  - Drive o_serclk=0, o_busy=0, o_valid=0.
  - Drive o_shreset=0 combinationally, so the shifter clears with the controller.
REQ-025 SHALL abort a frame immediately if i_reset asserts in SHIFT or DONE; no o_valid is produced for the aborted frame.
REQ-026 SHALL, after i_reset deasserts, remain in IDLE until a fresh i_start.

Configuration
REQ-027 SHALL provide macro SHIFT_SER_PARITY_EN.
REQ-028 With SHIFT_SER_PARITY_EN defined:
  - Each frame is a leading parity bit followed by WIDTH data bits, so N=WIDTH+1 falling edges.
  - The parity bit shifts out of the shifter, leaving only data.
  - The controller samples i_q at each i_clk edge where o_serclk goes 1->0 and XORs all N samples.
  - Output o_perr (1 bit) SHALL be valid with o_valid: 1 = even-parity violation.
  - o_perr resets to 0 and clears in CLEAR.
REQ-029 Without SHIFT_SER_PARITY_EN:
  - N=WIDTH.
  - o_perr port is absent.
  - No i_q sampling logic is present; i_q is unused.

Verification
REQ-030 WIDTH=8, DIV=4, one i_start pulse:
  - o_shreset low exactly 1 cycle.
  - 8 falling edges on o_serclk, 8 cycles apart.
  - o_valid rises 64 cycles after CLEAR exits.
  - o_bitcnt=8.
REQ-031 Hold i_ready low for 20 cycles in DONE:
  - o_valid stays high and o_serclk stays low throughout.
  - i_ready=1 -> IDLE next cycle and o_valid=0.
REQ-032 i_start and i_ready together in DONE:
  - Next cycle is CLEAR (o_shreset=0).
  - No IDLE cycle between frames.
REQ-033 i_reset low after 3 falling edges:
  - All outputs take reset values the same cycle.
  - o_valid never asserts.
  - A later i_start runs a full 8-edge frame.
REQ-034 Parity macro on, serial stream parity=1 then data 8'hA5:
  - 9 edges, o_perr=1.
  - With parity=0: o_perr=0.
  - Shifter holds 8'hA5 in both cases.
REQ-035 DIV=1:
  - o_serclk toggles every cycle.
  - Frame takes 16 SHIFT cycles.
  - i_start pulses during SHIFT do not extend or restart the frame.
